// File: rtl/coord_frame_parser.sv
// Frames ASCII "<x>,<y>\n" coordinate messages from a UART byte stream into two
// 32-bit unsigned values; malformed frames pulse frame_error and are skipped.
module coord_frame_parser #(
   parameter int unsigned MAX_DIGITS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] x_out,
   output logic [31:0] y_out,
   output logic        coord_valid,
   output logic        frame_error,
   output logic [7:0]  err_count,
   output logic        busy
);

   localparam logic [3:0] MaxCnt = 4'(MAX_DIGITS);

   typedef enum logic [1:0] {StIdle, StX, StY, StSkip} state_e;

   state_e      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] stage_q, stage_d;
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic [7:0]  err_q, err_d;
   logic        coord_valid_q, frame_error_q, busy_q;

   logic        is_digit, is_comma, is_nl, is_cr;
   logic        cnt_full;
   logic [31:0] digit_val;

   // Byte-level events decided by the FSM; the datapath acts on them.
   logic        ev_first, ev_digit, ev_to_y, ev_commit, ev_error;

   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_comma  = (rx_data == 8'h2C);
   assign is_nl     = (rx_data == 8'h0A);
   assign is_cr     = (rx_data == 8'h0D);
   assign cnt_full  = (cnt_q >= MaxCnt);
   assign digit_val = {28'd0, rx_data[3:0]};

   // State register and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         acc_q         <= '0;
         cnt_q         <= '0;
         stage_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         err_q         <= '0;
         coord_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         stage_q       <= stage_d;
         x_q           <= x_d;
         y_q           <= y_d;
         err_q         <= err_d;
         coord_valid_q <= ev_commit;
         frame_error_q <= ev_error;
         busy_q        <= (state_d != StIdle);
      end
   end

   // Next-state logic; carriage returns and idle cycles never move the FSM.
   always_comb begin
      state_d   = state_q;
      ev_first  = 1'b0;
      ev_digit  = 1'b0;
      ev_to_y   = 1'b0;
      ev_commit = 1'b0;
      ev_error  = 1'b0;
      if (rx_valid && !is_cr) begin
         unique case (state_q)
            StIdle: begin
               if (is_digit) begin
                  ev_first = 1'b1;
                  state_d  = StX;
               end else if (!is_nl) begin
                  ev_error = 1'b1;
                  state_d  = StSkip;
               end
            end
            StX: begin
               if (is_digit && !cnt_full) begin
                  ev_digit = 1'b1;
               end else if (is_comma && (cnt_q != 4'd0)) begin
                  ev_to_y = 1'b1;
                  state_d = StY;
               end else if (is_nl) begin
                  ev_error = 1'b1;
                  state_d  = StIdle;
               end else begin
                  ev_error = 1'b1;
                  state_d  = StSkip;
               end
            end
            StY: begin
               if (is_digit && !cnt_full) begin
                  ev_digit = 1'b1;
               end else if (is_nl && (cnt_q != 4'd0)) begin
                  ev_commit = 1'b1;
                  state_d   = StIdle;
               end else if (is_nl) begin
                  ev_error = 1'b1;
                  state_d  = StIdle;
               end else begin
                  ev_error = 1'b1;
                  state_d  = StSkip;
               end
            end
            StSkip: begin
               if (is_nl) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath: accumulator, staging register, published pair and error counter.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      if (ev_first) begin
         acc_d = digit_val;
         cnt_d = 4'd1;
      end else if (ev_digit) begin
         acc_d = (acc_q * 32'd10) + digit_val;
         cnt_d = cnt_q + 4'd1;
      end else if (ev_to_y) begin
         stage_d = acc_q;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (ev_commit) begin
         x_d     = stage_q;
         y_d     = acc_q;
         stage_d = '0;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (ev_error) begin
         stage_d = '0;
         acc_d   = '0;
         cnt_d   = '0;
         if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   assign x_out       = x_q;
   assign y_out       = y_q;
   assign coord_valid = coord_valid_q;
   assign frame_error = frame_error_q;
   assign err_count   = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_coord_frame_parser.sv
// Bench for coord_frame_parser: directed frame table, hand sequences for saturation and
// mid-frame reset, and random byte streams checked every cycle against a line-grammar model.
module tb_coord_frame_parser;

   localparam int MaxDigits = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [31:0] x_out, y_out;
   logic        coord_valid, frame_error, busy;
   logic [7:0]  err_count;

   always #5 clock = ~clock;

   coord_frame_parser #(.MAX_DIGITS(MaxDigits)) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .x_out       (x_out),
      .y_out       (y_out),
      .coord_valid (coord_valid),
      .frame_error (frame_error),
      .err_count   (err_count),
      .busy        (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a line is good iff it matches d{1,M} ',' d{1,M}; the first byte
   // that makes the line an impossible prefix is the error point.
   byte unsigned line[$];
   bit           m_dead = 1'b0;
   logic [31:0]  m_x = '0, m_y = '0;
   bit           m_cv = 1'b0, m_fe = 1'b0;
   int           m_err = 0;

   function automatic bit scan(input byte unsigned q[$], output int commas, output int len);
      commas = 0;
      len    = 0;
      foreach (q[i]) begin
         if (q[i] == 8'h2C) begin
            if (len == 0 || commas == 1) return 1'b0;
            commas++;
            len = 0;
         end else if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
            len++;
            if (len > MaxDigits) return 1'b0;
         end else begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic flag_error();
      m_fe = 1'b1;
      if (m_err < 255) m_err++;
   endtask

   task automatic model_byte(input byte unsigned b);
      int          commas, len, k;
      logic [31:0] f[2];
      if (b == 8'h0D) return;
      if (b == 8'h0A) begin
         if (!m_dead && line.size() != 0) begin
            if (scan(line, commas, len) && commas == 1 && len >= 1) begin
               f[0] = '0;
               f[1] = '0;
               k    = 0;
               foreach (line[i]) begin
                  if (line[i] == 8'h2C) k = 1;
                  else f[k] = f[k] * 10 + 32'(line[i] - 8'h30);
               end
               m_x  = f[0];
               m_y  = f[1];
               m_cv = 1'b1;
            end else begin
               flag_error();
            end
         end
         line.delete();
         m_dead = 1'b0;
      end else if (!m_dead) begin
         line.push_back(b);
         if (!scan(line, commas, len)) begin
            flag_error();
            m_dead = 1'b1;
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      m_cv = 1'b0;
      m_fe = 1'b0;
      if (reset) begin
         line.delete();
         m_dead = 1'b0;
         m_x    = '0;
         m_y    = '0;
         m_err  = 0;
      end else if (rx_valid) begin
         model_byte(rx_data);
      end
   end

   // Per-cycle comparison against the model, plus pulse counters for the table checks.
   bit chk_en = 1'b0;
   int cv_cnt = 0, fe_cnt = 0;

   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         chk("coord_valid", 32'(coord_valid), 32'(m_cv));
         chk("frame_error", 32'(frame_error), 32'(m_fe));
         chk("x_out", x_out, m_x);
         chk("y_out", y_out, m_y);
         chk("err_count", 32'(err_count), 32'(m_err));
         chk("busy", 32'(busy), 32'(m_dead || line.size() != 0));
         cv_cnt += 32'(coord_valid);
         fe_cnt += 32'(frame_error);
      end
   end

   // All driving happens on negative edges.
   task automatic send_byte(input byte unsigned b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   // '~' in a message stands for a carriage return.
   task automatic send_str(input string s, input int gap);
      for (int j = 0; j < s.len(); j++) begin
         byte unsigned b;
         b = s[j];
         if (b == 8'h7E) b = 8'h0D;
         send_byte(b, gap);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(negedge clock);
      reset  = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic settle();
      repeat (2) @(negedge clock);
      #1;
   endtask

   typedef struct {
      string       msg;
      int          gap;
      logic [31:0] x;
      logic [31:0] y;
      int          cv;
      int          fe;
      int          err;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{"123456,654321\n", 0, 32'd123456, 32'd654321, 1, 0, 0};
      tbl[1] = '{"7,0~\n", 2, 32'd7, 32'd0, 1, 0, 0};
      tbl[2] = '{"10,20\n1a,5\n", 0, 32'd10, 32'd20, 1, 1, 1};
      tbl[3] = '{"1234567,1\n3,4\n", 0, 32'd3, 32'd4, 1, 1, 1};
      tbl[4] = '{",5\n5,\n5\n5,6,7\n", 1, 32'd0, 32'd0, 0, 4, 4};
      tbl[5] = '{"\n\n42,9~\n", 0, 32'd42, 32'd9, 1, 0, 0};
      tbl[6] = '{"x5,1\n999999,0\n", 0, 32'd999999, 32'd0, 1, 1, 1};

      do_reset();
      #1;
      chk("reset x_out", x_out, 32'd0);
      chk("reset y_out", y_out, 32'd0);
      chk("reset err_count", 32'(err_count), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clock);

      foreach (tbl[i]) begin
         do_reset();
         cv_cnt = 0;
         fe_cnt = 0;
         send_str(tbl[i].msg, tbl[i].gap);
         settle();
         chk($sformatf("tbl%0d x_out", i), x_out, tbl[i].x);
         chk($sformatf("tbl%0d y_out", i), y_out, tbl[i].y);
         chk($sformatf("tbl%0d coord_valid count", i), 32'(cv_cnt), 32'(tbl[i].cv));
         chk($sformatf("tbl%0d frame_error count", i), 32'(fe_cnt), 32'(tbl[i].fe));
         chk($sformatf("tbl%0d err_count", i), 32'(err_count), 32'(tbl[i].err));
         chk($sformatf("tbl%0d busy idle", i), 32'(busy), 32'd0);
         @(negedge clock);
      end

      // Error counter saturation.
      do_reset();
      fe_cnt = 0;
      repeat (300) send_str(",\n", 0);
      settle();
      chk("sat err_count", 32'(err_count), 32'd255);
      chk("sat frame_error count", 32'(fe_cnt), 32'd300);
      @(negedge clock);

      // Reset in the middle of a frame, after a good pair was published.
      do_reset();
      cv_cnt = 0;
      send_str("5,6\n12,3", 0);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("midreset x_out", x_out, 32'd0);
      chk("midreset y_out", y_out, 32'd0);
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset coord_valid", 32'(coord_valid), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      cv_cnt = 0;
      send_str("8,9\n", 0);
      settle();
      chk("postreset x_out", x_out, 32'd8);
      chk("postreset y_out", y_out, 32'd9);
      chk("postreset coord_valid count", 32'(cv_cnt), 32'd1);
      @(negedge clock);

      // Random mix of good frames and garbage, checked cycle by cycle by the model.
      do_reset();
      for (int f = 0; f < 400; f++) begin
         int    gap;
         string pool;
         pool = "0123456789,,,x~\n";
         gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         if ($urandom_range(0, 39) == 0) do_reset();
         if ($urandom_range(0, 3) != 0) begin
            for (int fld = 0; fld < 2; fld++) begin
               int nd;
               nd = $urandom_range(1, MaxDigits + ($urandom_range(0, 9) == 0 ? 1 : 0));
               for (int d = 0; d < nd; d++) send_byte(8'(8'h30 + $urandom_range(0, 9)), gap);
               if (fld == 0) send_byte(8'h2C, gap);
            end
            if ($urandom_range(0, 4) == 0) send_byte(8'h0D, gap);
            send_byte(8'h0A, gap);
         end else begin
            int n;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
               byte unsigned b;
               b = pool[$urandom_range(0, pool.len() - 1)];
               if (b == 8'h7E) b = 8'h0D;
               send_byte(b, gap);
            end
            send_byte(8'h0A, gap);
         end
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
